// File: rtl/dct_pkg.sv
// Shared DCT datapath types: block dimension, coefficient width and row vectors.
package dct_pkg;

    localparam int unsigned DCT_N  = 8;
    localparam int unsigned COEF_W = 16;

    typedef logic [COEF_W-1:0] coef_t;
    typedef coef_t [DCT_N-1:0] coef_vec_t;

endpackage

// File: rtl/dct_tp_bank.sv
// One N x N coefficient bank: row-wide write port, combinational column read port.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int unsigned N = DCT_N,
    parameter int unsigned W = COEF_W
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               we,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_row,
    input  logic [N*W-1:0]                     wr_data,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] rd_col,
    output logic [N*W-1:0]                     rd_data
);

    logic [W-1:0] mem [N][N];

    // Row write; contents clear to zero on reset so partial blocks vanish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int c = 0; c < int'(N); c++) begin
                mem[wr_row][c] <= wr_data[c*W +: W];
            end
        end
    end

    // Column gather: element i of the output is row i of the selected column.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < int'(N); r++) begin
            rd_data[r*W +: W] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose buffer: fills one bank row-wise while the other drains column-wise.
module dct_transpose_buffer
    import dct_pkg::*;
#(
    parameter int unsigned N = DCT_N,
    parameter int unsigned W = COEF_W
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           val_input,
    output logic           in_ready,
    input  logic [N*W-1:0] row_in,
    output logic           val_output,
    input  logic           out_ready,
    output logic [N*W-1:0] col_out,
    output logic           col_first
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] wr_row_q, wr_row_d;
    logic [IW-1:0] rd_col_q, rd_col_d;
    logic          wr_acc, rd_acc;
    logic [N*W-1:0] col0, col1;

    dct_tp_bank #(.N(N), .W(W)) u_bank0 (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_acc && !wr_bank_q),
        .wr_row  (wr_row_q),
        .wr_data (row_in),
        .rd_col  (rd_col_q),
        .rd_data (col0)
    );

    dct_tp_bank #(.N(N), .W(W)) u_bank1 (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_acc && wr_bank_q),
        .wr_row  (wr_row_q),
        .wr_data (row_in),
        .rd_col  (rd_col_q),
        .rd_data (col1)
    );

    // Handshakes and read-side outputs come straight from registered state.
    always_comb begin
        in_ready   = !full_q[wr_bank_q];
        val_output = full_q[rd_bank_q];
        wr_acc     = val_input && in_ready;
        rd_acc     = val_output && out_ready;
        col_out    = rd_bank_q ? col1 : col0;
        col_first  = val_output && (rd_col_q == '0);
    end

    // Pointer and flag next state; write only ever sets an empty bank and read
    // only ever clears a full one, so both may apply in the same cycle.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        if (wr_acc) begin
            if (wr_row_q == IW'(N - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_row_d          = '0;
            end else begin
                wr_row_d = wr_row_q + IW'(1);
            end
        end
        if (rd_acc) begin
            if (rd_col_q == IW'(N - 1)) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_col_d          = '0;
            end else begin
                rd_col_d = rd_col_q + IW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer with hand-derived transposed columns.
module tb_dct_transpose_buffer;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 16;
    localparam int unsigned NW = N * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          val_input;
    logic          in_ready;
    logic [NW-1:0] row_in;
    logic          val_output;
    logic          out_ready;
    logic [NW-1:0] col_out;
    logic          col_first;

    int errors = 0;
    int checks = 0;

    dct_transpose_buffer #(.N(N), .W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .val_input  (val_input),
        .in_ready   (in_ready),
        .row_in     (row_in),
        .val_output (val_output),
        .out_ready  (out_ready),
        .col_out    (col_out),
        .col_first  (col_first)
    );

    always #5 clk = ~clk;

    // kind 0: {k, 0, r, c}; kind 1: A5A5 + index; kind 2: sign/extreme patterns
    function automatic logic [15:0] elem(int kind, int k, int r, int c);
        logic [15:0] pat [4];
        pat[0] = 16'h8000; pat[1] = 16'hFFFF; pat[2] = 16'h7FFF; pat[3] = 16'h0001;
        case (kind)
            0:       return {4'(k), 4'h0, 4'(r), 4'(c)};
            1:       return 16'hA5A5 + 16'(r * 8 + c);
            default: return pat[(r + c + k) % 4];
        endcase
    endfunction

    function automatic logic [NW-1:0] mk_row(int kind, int k, int r);
        logic [NW-1:0] v = '0;
        for (int c = 0; c < int'(N); c++) v[c*W +: W] = elem(kind, k, r, c);
        return v;
    endfunction

    function automatic logic [NW-1:0] mk_col(int kind, int k, int c);
        logic [NW-1:0] v = '0;
        for (int r = 0; r < int'(N); r++) v[r*W +: W] = elem(kind, k, r, c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, ".val_output"}, NW'(val_output), NW'(0));
        chk({tag, ".in_ready"},   NW'(in_ready),   NW'(1));
        chk({tag, ".col_out"},    col_out,         NW'(0));
        chk({tag, ".col_first"},  NW'(col_first),  NW'(0));
    endtask

    // Push 8 rows of a block; expects in_ready high on each.
    task automatic fill_block(input int kind, input int k, input string tag);
        for (int r = 0; r < int'(N); r++) begin
            val_input = 1'b1;
            row_in    = mk_row(kind, k, r);
            chk({tag, ".in_ready"}, NW'(in_ready), NW'(1));
            step();
        end
        val_input = 1'b0;
    endtask

    // Drain 8 columns with out_ready high, checking contents and col_first.
    task automatic drain_block(input int kind, input int k, input int c0, input string tag);
        out_ready = 1'b1;
        for (int c = c0; c < int'(N); c++) begin
            chk({tag, ".val_output"}, NW'(val_output), NW'(1));
            chk({tag, ".col_out"},    col_out,         mk_col(kind, k, c));
            chk({tag, ".col_first"},  NW'(col_first),  NW'(c == 0));
            step();
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        val_input = 1'b0;
        out_ready = 1'b0;
        row_in    = '0;
        #1;
        chk_idle_reset("reset_low");
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk_idle_reset("reset_release");

        // Single block, column 0 valid the cycle after row 7
        out_ready = 1'b1;
        fill_block(0, 0, "single_fill");
        drain_block(0, 0, 0, "single_drain");
        chk("single_empty", NW'(val_output), NW'(0));

        // Three blocks streaming at full rate in both directions
        out_ready = 1'b1;
        for (int t = 0; t < 32; t++) begin
            if (t < 24) begin
                val_input = 1'b1;
                row_in    = mk_row(0, 1 + t / 8, t % 8);
                chk("stream_in_ready", NW'(in_ready), NW'(1));
            end else begin
                val_input = 1'b0;
            end
            if (t >= 8) begin
                chk("stream_val", NW'(val_output), NW'(1));
                chk("stream_col", col_out, mk_col(0, 1 + (t - 8) / 8, (t - 8) % 8));
                chk("stream_first", NW'(col_first), NW'(((t - 8) % 8) == 0));
            end else begin
                chk("stream_prefill_val", NW'(val_output), NW'(0));
            end
            step();
        end
        val_input = 1'b0;
        chk("stream_empty", NW'(val_output), NW'(0));

        // Backpressure: two full blocks, 17th row must be held
        out_ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            val_input = 1'b1;
            row_in    = mk_row(0, 5 + n / 8, n % 8);
            chk("bp_in_ready", NW'(in_ready), NW'(1));
            step();
        end
        row_in = mk_row(0, 7, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall_ready", NW'(in_ready), NW'(0));
            chk("bp_stall_val", NW'(val_output), NW'(1));
            chk("bp_stall_col", col_out, mk_col(0, 5, 0));
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < int'(N); c++) begin
            chk("bp_drain_ready", NW'(in_ready), NW'(0));
            chk("bp_drain_col", col_out, mk_col(0, 5, c));
            step();
        end
        chk("bp_resume_ready", NW'(in_ready), NW'(1));
        chk("bp_resume_col", col_out, mk_col(0, 6, 0));
        chk("bp_resume_first", NW'(col_first), NW'(1));
        step();
        val_input = 1'b0;
        drain_block(0, 6, 1, "bp_blk6");
        chk("bp_blk6_empty", NW'(val_output), NW'(0));
        for (int r = 1; r < int'(N); r++) begin
            val_input = 1'b1;
            row_in    = mk_row(0, 7, r);
            chk("bp_blk7_ready", NW'(in_ready), NW'(1));
            chk("bp_blk7_notyet", NW'(val_output), NW'(0));
            step();
        end
        val_input = 1'b0;
        drain_block(0, 7, 0, "bp_blk7");
        chk("bp_blk7_empty", NW'(val_output), NW'(0));

        // Reset mid-block discards the partial rows
        for (int r = 0; r < 5; r++) begin
            val_input = 1'b1;
            row_in    = mk_row(0, 3, r);
            step();
        end
        val_input = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_reset("mid_reset_low");
        step();
        reset_n = 1'b1;
        #1;
        chk_idle_reset("mid_reset_release");
        fill_block(1, 0, "after_reset_fill");
        drain_block(1, 0, 0, "after_reset_drain");
        chk("after_reset_empty", NW'(val_output), NW'(0));

        // Extreme values pass through bit-identical
        fill_block(2, 0, "bits_fill");
        drain_block(2, 0, 0, "bits_drain");
        chk("bits_empty", NW'(val_output), NW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
